// File: rtl/edge_pattern_gen.sv
`default_nettype none
// ============================================================================
// edge_pattern_gen : programmable high/low waveform generator with edge strobe.
// Optional macro EDGE_PATTERN_GEN_IDLE_HIGH_EN: idle level 1, low phase first.
// Revision: 1.0
// ============================================================================
module edge_pattern_gen #(
  parameter int LEN_W = 8,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             edge_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

`ifdef EDGE_PATTERN_GEN_IDLE_HIGH_EN
  localparam logic   IDLE_LVL  = 1'b1;
  localparam state_t FIRST_ST  = ST_LOW;
  localparam state_t SECOND_ST = ST_HIGH;
`else
  localparam logic   IDLE_LVL  = 1'b0;
  localparam state_t FIRST_ST  = ST_HIGH;
  localparam state_t SECOND_ST = ST_LOW;
`endif

  // Phase lengths are stored as (cycles - 1) so zero naturally means one cycle.
  function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [LEN_W-1:0] hi_m1_q, hi_m1_d;
  logic [LEN_W-1:0] lo_m1_q, lo_m1_d;
  logic             out_q, out_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             enter;
  state_t           enter_st;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    hi_m1_d  = hi_m1_q;
    lo_m1_d  = lo_m1_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    enter    = 1'b0;
    enter_st = FIRST_ST;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (reps != '0) begin
            hi_m1_d  = len_m1(high_len);
            lo_m1_d  = len_m1(low_len);
            rep_d    = reps;
            busy_d   = 1'b1;
            enter    = 1'b1;
            enter_st = FIRST_ST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH, ST_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else if (state_q == FIRST_ST) begin
          enter    = 1'b1;
          enter_st = SECOND_ST;
        end else if (rep_q == REP_W'(1)) begin
          state_d = ST_IDLE;
          out_d   = IDLE_LVL;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          rep_d   = '0;
        end else begin
          rep_d    = rep_q - REP_W'(1);
          enter    = 1'b1;
          enter_st = FIRST_ST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = IDLE_LVL;
        busy_d  = 1'b0;
        cnt_d   = '0;
        rep_d   = '0;
      end
    endcase

    // Uses the _d lengths so the cycle of acceptance loads the fresh inputs.
    if (enter) begin
      state_d = enter_st;
      out_d   = (enter_st == ST_HIGH);
      cnt_d   = (enter_st == ST_HIGH) ? hi_m1_d : lo_m1_d;
    end

    strobe_d = out_d ^ out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rep_q    <= '0;
      hi_m1_q  <= '0;
      lo_m1_q  <= '0;
      out_q    <= IDLE_LVL;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      hi_m1_q  <= hi_m1_d;
      lo_m1_q  <= lo_m1_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out         = out_q;
  assign edge_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_edge_pattern_gen : randomized self-checking bench with a waveform-list model.
// Revision: 1.0
// ============================================================================
module tb_edge_pattern_gen;

`ifdef EDGE_PATTERN_GEN_IDLE_HIGH_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] high_len_i = 8'd0;
  logic [7:0] low_len_i = 8'd0;
  logic [7:0] reps_i = 8'd0;
  logic       out, edge_strobe, busy, done;

  always #5 clk = ~clk;

  edge_pattern_gen #(.LEN_W(8), .REP_W(8)) dut (
    .clk        (clk),
    .reset      (reset_i),
    .start      (start_i),
    .high_len   (high_len_i),
    .low_len    (low_len_i),
    .reps       (reps_i),
    .out        (out),
    .edge_strobe(edge_strobe),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {logic o; logic b; logic d;} exp_t;
  exp_t q[$];

  logic exp_out = IDLE_LVL, exp_strobe = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Expected waveform for one accepted request: R periods then one done cycle.
  task automatic push_pattern(input int h, input int l, input int r);
    int a_len, b_len;
    h = (h == 0) ? 1 : h;
    l = (l == 0) ? 1 : l;
`ifdef EDGE_PATTERN_GEN_IDLE_HIGH_EN
    a_len = l; b_len = h;
`else
    a_len = h; b_len = l;
`endif
    for (int p = 0; p < r; p++) begin
      for (int i = 0; i < a_len; i++) q.push_back({~IDLE_LVL, 1'b1, 1'b0});
      for (int i = 0; i < b_len; i++) q.push_back({IDLE_LVL, 1'b1, 1'b0});
    end
    q.push_back({IDLE_LVL, 1'b0, 1'b1});
  endtask

  // Advance one clock and move the model to the cycle that follows the edge.
  task automatic step();
    exp_t nx;
    logic prev;
    @(posedge clk);
    cyc++;
    prev = exp_out;
    if (reset_i) begin
      q.delete();
      exp_out = IDLE_LVL; exp_busy = 1'b0; exp_done = 1'b0; exp_strobe = 1'b0;
    end else begin
      if (start_i && !exp_busy)
        push_pattern(int'(high_len_i), int'(low_len_i), int'(reps_i));
      if (q.size() > 0) nx = q.pop_front();
      else nx = {IDLE_LVL, 1'b0, 1'b0};
      exp_out = nx.o; exp_busy = nx.b; exp_done = nx.d;
      exp_strobe = (exp_out != prev);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {IDLE_LVL, 3'b000}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got out/strb/busy/done=%b required=%b",
                 cyc, {out, edge_strobe, busy, done}, {IDLE_LVL, 3'b000});
      end
    end
  endtask

  task automatic test_basic();
    int strobes = 0, busy_cnt = 0, done_at = -1;
    high_len_i = 8'd2; low_len_i = 8'd6; reps_i = 8'd4;
    start_i = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      step();
      start_i = 1'b0;
      strobes += int'(edge_strobe);
      busy_cnt += int'(busy);
      if (done === 1'b1) done_at = i;
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {exp_out, exp_strobe, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got out/strb/busy/done=%b required=%b", cyc,
                 {out, edge_strobe, busy, done}, {exp_out, exp_strobe, exp_busy, exp_done});
      end
    end
    n_cmp++;
    if (strobes != 8) begin
      n_fail++; $display("FAIL basic_strobe_count got %0d required 8", strobes);
    end
    n_cmp++;
    if (busy_cnt != 32) begin
      n_fail++; $display("FAIL basic_busy_cycles got %0d required 32", busy_cnt);
    end
    n_cmp++;
    if (done_at != 33) begin
      n_fail++; $display("FAIL basic_done_offset got %0d required 33", done_at);
    end
  endtask

  task automatic test_zero_len();
    int strobes = 0;
    high_len_i = 8'd0; low_len_i = 8'd0; reps_i = 8'd3;
    start_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      start_i = 1'b0;
      if (i <= 6) strobes += int'(edge_strobe);
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {exp_out, exp_strobe, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL zero_len cyc=%0d got out/strb/busy/done=%b required=%b", cyc,
                 {out, edge_strobe, busy, done}, {exp_out, exp_strobe, exp_busy, exp_done});
      end
    end
    n_cmp++;
    if (strobes != 6) begin
      n_fail++; $display("FAIL zero_len_strobes got %0d required 6", strobes);
    end
  endtask

  task automatic test_reps_zero();
    high_len_i = 8'd4; low_len_i = 8'd4; reps_i = 8'd0;
    start_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      start_i = 1'b0;
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {IDLE_LVL, 2'b00, (i == 1)}) begin
        n_fail++;
        $display("FAIL reps_zero cyc=%0d got out/strb/busy/done=%b required=%b", cyc,
                 {out, edge_strobe, busy, done}, {IDLE_LVL, 2'b00, (i == 1)});
      end
    end
  endtask

  task automatic test_back_to_back();
    bit   restarted = 0;
    logic chk_rise = 1'b0;
    high_len_i = 8'd3; low_len_i = 8'd3; reps_i = 8'd2;
    start_i = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      start_i = 1'b0;
      if (i == 4 || i == 8) begin
        high_len_i = 8'd7; low_len_i = 8'd1; reps_i = 8'd5; start_i = 1'b1;
      end else if (i == 9) begin
        high_len_i = 8'd3; low_len_i = 8'd3; reps_i = 8'd2;
      end
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {exp_out, exp_strobe, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got out/strb/busy/done=%b required=%b", cyc,
                 {out, edge_strobe, busy, done}, {exp_out, exp_strobe, exp_busy, exp_done});
      end
      if (chk_rise) begin
        chk_rise = 1'b0;
        n_cmp++;
        if (out !== ~IDLE_LVL || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL restart_on_done cyc=%0d got out=%b busy=%b required out=%b busy=1",
                   cyc, out, busy, ~IDLE_LVL);
        end
      end
      if (exp_done && !restarted) begin
        restarted = 1; start_i = 1'b1; chk_rise = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    high_len_i = 8'd5; low_len_i = 8'd4; reps_i = 8'd2;
    start_i = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 4) reset_i = 1'b1;
      if (i == 6) start_i = 1'b1;
      step();
      start_i = 1'b0; reset_i = 1'b0;
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {exp_out, exp_strobe, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL reset_mid cyc=%0d got out/strb/busy/done=%b required=%b", cyc,
                 {out, edge_strobe, busy, done}, {exp_out, exp_strobe, exp_busy, exp_done});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      start_i    = ($urandom_range(0, 3) == 0);
      reset_i    = ($urandom_range(0, 199) == 0);
      high_len_i = 8'($urandom_range(0, 5));
      low_len_i  = 8'($urandom_range(0, 5));
      reps_i     = 8'($urandom_range(0, 3));
      step();
      n_cmp++;
      if ({out, edge_strobe, busy, done} !== {exp_out, exp_strobe, exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got out/strb/busy/done=%b required=%b", cyc,
                 {out, edge_strobe, busy, done}, {exp_out, exp_strobe, exp_busy, exp_done});
      end
    end
    start_i = 1'b0; reset_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_reps_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_pattern_gen.md
# edge_pattern_gen

Programmable two-level waveform generator: the stimulus end of the `double_edge_detect` interface. On a start request it drives `out` high for a programmed number of cycles, then low for a programmed number of cycles, repeating for a programmed count. It also emits a one-cycle strobe on every transition it makes, so a downstream edge detector's `out` can be checked against it cycle-for-cycle. It replaces hand-written toggle logic in benches and serves as an on-chip test-pattern source.

## Interface

Parameters:
- `LEN_W`, default 8: width of the phase-length inputs.
- `REP_W`, default 8: width of the repetition-count input.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request pulse; sampled only while idle.
- `high_len`  input  LEN_W  high-phase length in cycles; captured on accepted `start`.
- `low_len`  input  LEN_W  low-phase length in cycles; captured on accepted `start`.
- `reps`  input  REP_W  number of high/low periods; captured on accepted `start`.
- `out`  output  1  generated waveform (registered).
- `edge_strobe`  output  1  one-cycle pulse when `out` changes (registered).
- `busy`  output  1  high from acceptance until the pattern completes.
- `done`  output  1  one-cycle completion pulse.

## Operation

- State machine states: IDLE, HIGH, LOW.
  - IDLE + `start` + `reps`≠0: go to HIGH. Set `out`=1 and `busy`=1. Load the phase counter with `high_len`.
  - IDLE + `start` + `reps`=0: stay in IDLE. Pulse `done` on the next cycle. `out` does not change.
  - HIGH, counter expires: go to LOW. Set `out`=0 and load `low_len`.
  - LOW, counter expires, periods remain: go to HIGH. Set `out`=1, load `high_len`, and decrement the remaining-period count.
  - LOW, counter expires, last period: go to IDLE. Set `busy`=0 and `done`=1.
- Phase length 0 is treated as 1. No phase is ever skipped.
- Inputs are captured at acceptance. Changes to them during the pattern have no effect.
- `start` while `busy` is ignored, with no queueing.
- Counters are unsigned. Maximum phase length is 2^LEN_W−1 cycles. Maximum period count is 2^REP_W−1.
- Reset values: `out`=0, `edge_strobe`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset mid-pattern aborts immediately on that edge. Every output returns to its reset value and `done` is not pulsed.

## Timing

- Let edge k be the edge at which `start` is accepted.
  - `out`=1 during cycles k+1 … k+H, where H=max(`high_len`,1).
  - `out`=0 during the next L cycles, where L=max(`low_len`,1).
  - Period = H+L cycles.
- `edge_strobe`=1 in exactly the cycle in which `out` first shows its new value. This applies to both rising and falling transitions.
- Pattern end:
  - The final falling edge produces a strobe as usual.
  - `done`=1 and `busy`=0 in the cycle immediately after the last low cycle.
  - Total busy duration = R·(H+L) cycles, where R=`reps`.
- `done` cycle: the block is in IDLE, so `start` sampled in that cycle is accepted and `out` rises on the next cycle. Back-to-back patterns therefore have exactly one `done` cycle of low gap. That gap extends the final low phase by one cycle.
- `reps`=0: `done` pulses in cycle k+1 and `busy` never asserts.
- `start` and `reset` high on the same edge: reset wins.

## Configuration

- Macro: `EDGE_PATTERN_GEN_IDLE_HIGH_EN`.
- Defined:
  - The idle and reset level of `out` is 1.
  - Phase order becomes low phase (`low_len`) first, then high phase (`high_len`).
  - All strobe, `busy` and `done` timing is otherwise identical.
- Undefined: idle/reset level is 0, with the ordering described above.

## Test plan

- Reset release, no `start` for 20 cycles → `out`, `edge_strobe`, `busy`, `done` all 0 throughout.
- `high_len`=2, `low_len`=6, `reps`=4, `start` at cycle 10 →
  - `out` high for cycles 11–12, 19–20, 27–28, 35–36.
  - 8 strobes total, at 11, 13, 19, 21, …
  - `done` at cycle 43; `busy` high for cycles 11–42.
- `high_len`=0, `low_len`=0, `reps`=3 → `out` toggles every cycle for 6 cycles, strobe high for all 6 cycles, `done` 1 cycle after.
- `reps`=0 with `start` at cycle 5 → `done` at cycle 6, `busy` and `out` stay 0.
- Pattern `high_len`=3, `low_len`=3, `reps`=2:
  - Pulse `start` mid-pattern with different inputs → ignored; the original pattern completes unchanged.
  - `start` during the `done` cycle → new pattern's `out` rises on the next cycle.
- `reset` asserted in the middle of a HIGH phase → next cycle `out`=0, `busy`=0, no `done`. A later `start` runs a full pattern normally.
